// File: rtl/puf_pkg.sv
`default_nettype none
// ============================================================================
// Module  : puf_pkg
// Brief   : Shared types and defaults for the ring-oscillator race arbiter.
// Revision: 1.0
// ============================================================================
package puf_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RACE   = 2'd2,
    REPORT = 2'd3
  } arb_state_e;

  // Winner encoding
  localparam logic WIN_A = 1'b0;
  localparam logic WIN_B = 1'b1;

  // Default race parameters
  localparam int DEF_THRESHOLD     = 1000;
  localparam int DEF_SETTLE_CYCLES = 8;

endpackage
`default_nettype wire

// File: rtl/ro_edge_counter.sv
`default_nettype none
// ============================================================================
// Module  : ro_edge_counter
// Brief   : Synchronises one asynchronous oscillator output, detects rising
//           edges and counts them, saturating at THRESHOLD.
// Revision: 1.0
// ============================================================================
module ro_edge_counter #(
  parameter int CNT_W     = 16,
  parameter int THRESHOLD = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic ro_i,
  input  logic clr_i,
  input  logic en_i,
  output logic reach_o
);

  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESHOLD);

  logic             sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             edge_w;

  assign edge_w  = sync2_q & ~prev_q;
  assign reach_o = (cnt_q == THR);

  // Next count: clear wins, otherwise count qualified edges up to THRESHOLD
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && edge_w && (cnt_q != THR)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Two-flop synchroniser, edge-detect flop and edge counter
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= ro_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/race_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : race_arbiter
// Brief   : Runs one race between two ring oscillators and reports which one
//           produced THRESHOLD rising edges first (or tie / timeout).
// Revision: 1.0
// ============================================================================
module race_arbiter
  import puf_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int THRESHOLD     = DEF_THRESHOLD,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT       = 65535,
  parameter int TO_W          = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic ro_a,
  input  logic ro_b,
  output logic ro_en,
  output logic winner,
  output logic done,
  output logic busy,
  output logic tie,
  output logic timeout
);

  localparam int             SET_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             winner_q, winner_d;
  logic             tie_q, tie_d;
  logic             timeout_q, timeout_d;
  logic             reach_a, reach_b;
  logic             cnt_clr, cnt_en;

  // Counters are held cleared for the whole settle window and only count in RACE
  assign cnt_clr = (state_q == SETTLE);
  assign cnt_en  = (state_q == RACE);

  ro_edge_counter #(.CNT_W(CNT_W), .THRESHOLD(THRESHOLD)) u_cnt_a (
    .clk     (clk),
    .rst     (rst),
    .ro_i    (ro_a),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .reach_o (reach_a)
  );

  ro_edge_counter #(.CNT_W(CNT_W), .THRESHOLD(THRESHOLD)) u_cnt_b (
    .clk     (clk),
    .rst     (rst),
    .ro_i    (ro_b),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .reach_o (reach_b)
  );

  // Next-state logic; result flags change only on the RACE -> REPORT step
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    to_d      = to_q;
    winner_d  = winner_q;
    tie_d     = tie_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        settle_d = '0;
        to_d     = '0;
        if (start) state_d = SETTLE;
      end
      SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = RACE;
        else                         settle_d = settle_q + 1'b1;
      end
      RACE: begin
        // A reach always beats a simultaneous timeout expiry
        if (reach_a || reach_b) begin
          state_d   = REPORT;
          winner_d  = (reach_b && !reach_a) ? WIN_B : WIN_A;
          tie_d     = reach_a && reach_b;
          timeout_d = 1'b0;
        end else if (to_q == TO_LAST) begin
          state_d   = REPORT;
          winner_d  = WIN_A;
          tie_d     = 1'b0;
          timeout_d = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      REPORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      settle_q  <= '0;
      to_q      <= '0;
      winner_q  <= 1'b0;
      tie_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      to_q      <= to_d;
      winner_q  <= winner_d;
      tie_q     <= tie_d;
      timeout_q <= timeout_d;
    end
  end

  assign ro_en   = (state_q == SETTLE) || (state_q == RACE);
  assign done    = (state_q == REPORT);
  assign busy    = (state_q != IDLE);
  assign winner  = winner_q;
  assign tie     = tie_q;
  assign timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_race_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_race_arbiter
// Brief   : Scoreboard bench for race_arbiter (THRESHOLD=8, SETTLE=4,
//           TIMEOUT=200) with clock-divided oscillator models.
// Revision: 1.0
// ============================================================================
module tb_race_arbiter;

  localparam int THR = 8;
  localparam int SET = 4;
  localparam int TMO = 200;

  logic clk = 1'b0;
  logic rst, start, ro_a, ro_b;
  logic ro_en, winner, done, busy, tie, timeout;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int exp_done = 0;
  logic [2:0] exp_q[$];   // {winner, tie, timeout}

  // Oscillator model controls (period in clk cycles, 0 = held low)
  int pa = 0, pb = 0, ca = 0, cb = 0;
  bit tie_mode = 1'b0;

  always #5 clk = ~clk;

  race_arbiter #(
    .CNT_W(16), .THRESHOLD(THR), .SETTLE_CYCLES(SET), .TIMEOUT(TMO), .TO_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ro_a(ro_a), .ro_b(ro_b),
    .ro_en(ro_en), .winner(winner), .done(done), .busy(busy),
    .tie(tie), .timeout(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Oscillator waveforms, changed away from the sampling edge
  always @(negedge clk) begin
    if (pa == 0) begin ro_a = 1'b0; ca = 0; end
    else begin ca++; if (ca >= pa / 2) begin ca = 0; ro_a = ~ro_a; end end
    if (tie_mode) ro_b = ro_a;
    else if (pb == 0) begin ro_b = 1'b0; cb = 0; end
    else begin cb++; if (cb >= pb / 2) begin cb = 0; ro_b = ~ro_b; end end
  end

  // Scoreboard: every done pulse consumes one expected result
  always @(negedge clk) begin
    if (done === 1'b1) begin
      logic [2:0] e;
      done_cnt++;
      chk("queue_depth_at_done", exp_q.size(), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("winner", winner, e[2]);
        chk("tie", tie, e[1]);
        chk("timeout", timeout, e[0]);
      end
    end
  end

  // Launch one race and wait (bounded) for its done pulse; returns latency
  task automatic run_race(input int pa_i, input int pb_i, input bit tie_i,
                          input logic [2:0] exp, output int lat);
    bit busy_ok;
    int k;
    pa = pa_i; pb = pb_i; tie_mode = tie_i;
    repeat (3) @(negedge clk);
    start = 1'b1;
    exp_q.push_back(exp);
    exp_done++;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    busy_ok = 1'b1;
    while (done !== 1'b1 && k < 1000) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      k++;
    end
    chk("race_done_seen", done, 1);
    chk("busy_during_race", busy_ok, 1);
    lat = k;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
  endtask

  initial begin
    int lat;
    rst = 1'b1; start = 1'b0;
    #1 watchdog_arm();
    repeat (3) @(negedge clk);
    chk("rst_ro_en", ro_en, 0);
    chk("rst_winner", winner, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tie", tie, 0);
    chk("rst_timeout", timeout, 0);
    rst = 1'b0;
    @(negedge clk);

    // A faster
    run_race(6, 10, 1'b0, 3'b000, lat);
    // B faster, then winner must hold through IDLE
    run_race(12, 4, 1'b0, 3'b100, lat);
    repeat (5) @(negedge clk);
    chk("winner_hold_idle", winner, 1);
    // A faster again
    run_race(4, 12, 1'b0, 3'b000, lat);
    // identical waveforms -> tie
    run_race(6, 6, 1'b1, 3'b010, lat);
    // too slow -> timeout at RACE cycle TMO
    run_race(40, 0, 1'b0, 3'b001, lat);
    chk("timeout_latency", lat, SET + TMO + 1);

    // B wins so that the reset below must visibly clear winner
    run_race(12, 4, 1'b0, 3'b100, lat);

    // reset at RACE cycle 10: no done, back to IDLE
    pa = 6; pb = 10; tie_mode = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (SET + 10 - 1) @(negedge clk);
    chk("ro_en_in_race", ro_en, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_ro_en", ro_en, 0);
    chk("midrst_done", done, 0);
    chk("midrst_winner", winner, 0);
    repeat (100) @(negedge clk);
    chk("midrst_no_done", done_cnt, exp_done);

    // extra starts during SETTLE and RACE are ignored
    @(negedge clk);
    start = 1'b1;
    exp_q.push_back(3'b000);
    exp_done++;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (300) @(negedge clk);
    chk("one_done_per_start", done_cnt, exp_done);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the run can never hang
  task automatic watchdog_arm();
    fork
      begin
        #1000000;
        $display("FAIL watchdog got=expired exp=finished");
        $fatal(1, "watchdog");
      end
    join_none
  endtask

endmodule
`default_nettype wire
